cp0_exc_reg: RTL

Parametrised coprocessor-0 register block for the OpenMIPS core with full exception and interrupt entry/return. Holds Count, Compare, Status, Cause, EPC, PRId and Config. Takes the MEM-stage exception report and the WB-stage `mtc0` write. Decides in the same cycle whether to redirect the pipeline, driving the flush and new-PC outputs consumed by `ctrl` and `pc_reg`. Generalises the timer-only CP0 with a configurable interrupt-line count, a Count prescaler, a configurable timer-interrupt line and a configurable exception vector.

---
 rtl/cp0_exc_reg_if.sv | 36 +++
 rtl/cp0_exc_reg.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/cp0_exc_reg_if.sv
// Pipeline-side bundle for the CP0 block: WB write port, read port,
// MEM-stage exception report, redirect outputs and register views.
interface cp0_exc_reg_if #(
    parameter int HW_INT_NUM = 6
);
    logic                  we_i;
    logic [4:0]            waddr_i;
    logic [31:0]           data_i;
    logic [4:0]            raddr_i;
    logic [31:0]           data_o;
    logic [HW_INT_NUM-1:0] int_i;
    logic                  inst_valid_i;
    logic                  exc_valid_i;
    logic [4:0]            exc_code_i;
    logic                  eret_i;
    logic [31:0]           exc_pc_i;
    logic                  exc_in_delayslot_i;
    logic                  flush_o;
    logic [31:0]           new_pc_o;
    logic                  timer_int_o;
    logic [31:0]           status_o;
    logic [31:0]           cause_o;
    logic [31:0]           epc_o;

    modport slave (
        input  we_i, waddr_i, data_i, raddr_i, int_i, inst_valid_i,
               exc_valid_i, exc_code_i, eret_i, exc_pc_i, exc_in_delayslot_i,
        output data_o, flush_o, new_pc_o, timer_int_o, status_o, cause_o, epc_o
    );

    modport master (
        output we_i, waddr_i, data_i, raddr_i, int_i, inst_valid_i,
               exc_valid_i, exc_code_i, eret_i, exc_pc_i, exc_in_delayslot_i,
        input  data_o, flush_o, new_pc_o, timer_int_o, status_o, cause_o, epc_o
    );
endinterface

// File: rtl/cp0_exc_reg.sv
// Coprocessor-0 register block: Count/Compare timer with prescaler, Status,
// Cause, EPC, PRId, Config, plus combinational exception/interrupt redirect.
module cp0_exc_reg #(
    parameter int          HW_INT_NUM     = 6,
    parameter int          TIMER_INT_LINE = 5,
    parameter int          COUNT_DIV      = 1,
    parameter logic [31:0] EXC_VECTOR     = 32'h0000_0020,
    parameter logic [31:0] RESET_STATUS   = 32'h1000_0000,
    parameter logic [31:0] PRID           = 32'h004c_0102,
    parameter logic [31:0] CONFIG         = 32'h0000_8000
) (
    input  logic          clk,
    input  logic          rst,
    cp0_exc_reg_if.slave  bus
);

    localparam logic [4:0] REG_COUNT   = 5'd9;
    localparam logic [4:0] REG_COMPARE = 5'd11;
    localparam logic [4:0] REG_STATUS  = 5'd12;
    localparam logic [4:0] REG_CAUSE   = 5'd13;
    localparam logic [4:0] REG_EPC     = 5'd14;
    localparam logic [4:0] REG_PRID    = 5'd15;
    localparam logic [4:0] REG_CONFIG  = 5'd16;
    localparam logic [7:0] DIV_LAST    = 8'(COUNT_DIV - 1);

    logic [31:0] count;
    logic [31:0] compare;
    logic [31:0] status;
    logic [31:0] cause;
    logic [31:0] epc;
    logic [7:0]  div_cnt;
    logic        timer_int;

    logic [31:0] status_nxt;
    logic [31:0] cause_nxt;
    logic [31:0] epc_nxt;
    logic [7:0]  hw_ip;
    logic        int_pending;
    logic        take_int;
    logic        take_exc;
    logic        take_eret;

    always_comb begin
        hw_ip = '0;
        for (int i = 0; i < HW_INT_NUM; i++) begin
            hw_ip[2+i] = bus.int_i[i] | ((i == TIMER_INT_LINE) ? timer_int : 1'b0);
        end
    end

    assign int_pending = (|(hw_ip & status[15:8])) && status[0] && !status[1]
                         && bus.inst_valid_i;

    // Gated by rst so the redirect stays quiet while the block is held in reset.
    assign take_int  = !rst && int_pending;
    assign take_exc  = !rst && !int_pending && bus.exc_valid_i;
    assign take_eret = !rst && !int_pending && !bus.exc_valid_i && bus.eret_i;

    assign bus.flush_o  = take_int || take_exc || take_eret;
    assign bus.new_pc_o = (take_int || take_exc) ? EXC_VECTOR :
                          take_eret              ? epc        : 32'h0;

    // WB write lands first, then the accepted event overrides EXL/ExcCode/BD/EPC.
    always_comb begin
        status_nxt        = status;
        cause_nxt         = cause;
        epc_nxt           = epc;
        cause_nxt[15:10]  = hw_ip[7:2];
        if (bus.we_i) begin
            case (bus.waddr_i)
                REG_STATUS: status_nxt      = bus.data_i;
                REG_CAUSE:  cause_nxt[9:8]  = bus.data_i[9:8];
                REG_EPC:    epc_nxt         = bus.data_i;
                default: ;
            endcase
        end
        if (take_int || take_exc) begin
            cause_nxt[6:2] = take_int ? 5'd0 : bus.exc_code_i;
            if (!status[1]) begin
                epc_nxt       = bus.exc_in_delayslot_i ? bus.exc_pc_i - 32'd4 : bus.exc_pc_i;
                cause_nxt[31] = bus.exc_in_delayslot_i;
            end
            status_nxt[1] = 1'b1;
        end else if (take_eret) begin
            status_nxt[1] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count     <= '0;
            compare   <= '0;
            status    <= RESET_STATUS;
            cause     <= '0;
            epc       <= '0;
            div_cnt   <= '0;
            timer_int <= 1'b0;
        end else begin
            status <= status_nxt;
            cause  <= cause_nxt;
            epc    <= epc_nxt;

            if (bus.we_i && bus.waddr_i == REG_COUNT) begin
                count   <= bus.data_i;
                div_cnt <= '0;
            end else if (div_cnt == DIV_LAST) begin
                count   <= count + 32'd1;
                div_cnt <= '0;
            end else begin
                div_cnt <= div_cnt + 8'd1;
            end

            // A Compare write clears the sticky flag even if a match lands on this edge.
            if (bus.we_i && bus.waddr_i == REG_COMPARE) begin
                compare   <= bus.data_i;
                timer_int <= 1'b0;
            end else if (compare != 32'h0 && count == compare) begin
                timer_int <= 1'b1;
            end
        end
    end

    always_comb begin
        case (bus.raddr_i)
            REG_COUNT:   bus.data_o = count;
            REG_COMPARE: bus.data_o = compare;
            REG_STATUS:  bus.data_o = status;
            REG_CAUSE:   bus.data_o = cause;
            REG_EPC:     bus.data_o = epc;
            REG_PRID:    bus.data_o = PRID;
            REG_CONFIG:  bus.data_o = CONFIG;
            default:     bus.data_o = 32'h0;
        endcase
    end

    assign bus.timer_int_o = timer_int;
    assign bus.status_o    = status;
    assign bus.cause_o     = cause;
    assign bus.epc_o       = epc;

endmodule
